// File: rtl/arm_dp_pkg.sv
// Shared encodings for the ARM data-processing control path: FSM states,
// ALU command and condition constants, and the condition evaluation rule.
package arm_dp_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_ALUWB   = 3'd3,
    ST_ILLEGAL = 3'd4
  } state_t;

  // Field view of a data-processing instruction word.
  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm;
    logic [3:0]  cmd;
    logic        s;
    logic [19:0] rest;
  } dp_instr_t;

  localparam logic [3:0] CMD_AND = 4'h0;
  localparam logic [3:0] CMD_EOR = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_RSB = 4'h3;
  localparam logic [3:0] CMD_ADD = 4'h4;
  localparam logic [3:0] CMD_ADC = 4'h5;
  localparam logic [3:0] CMD_SBC = 4'h6;
  localparam logic [3:0] CMD_RSC = 4'h7;
  localparam logic [3:0] CMD_TST = 4'h8;
  localparam logic [3:0] CMD_TEQ = 4'h9;
  localparam logic [3:0] CMD_CMP = 4'hA;
  localparam logic [3:0] CMD_CMN = 4'hB;
  localparam logic [3:0] CMD_ORR = 4'hC;
  localparam logic [3:0] CMD_MOV = 4'hD;
  localparam logic [3:0] CMD_BIC = 4'hE;
  localparam logic [3:0] CMD_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // nzcv is packed {N,Z,C,V}; COND_NV never passes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c && !z;
      COND_LS: cond_holds = !c || z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = !z && (n == v);
      COND_LE: cond_holds = z || (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

  // Compare/test commands only set flags and never write Rd.
  function automatic logic is_compare(input logic [3:0] cmd);
    is_compare = (cmd inside {CMD_TST, CMD_TEQ, CMD_CMP, CMD_CMN});
  endfunction

  // Commands whose carry and overflow come from the adder.
  function automatic logic is_arith(input logic [3:0] cmd);
    is_arith = (cmd inside {CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
                            CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN});
  endfunction

  function automatic logic is_logical(input logic [3:0] cmd);
    is_logical = (cmd inside {CMD_AND, CMD_EOR, CMD_TST, CMD_TEQ,
                              CMD_ORR, CMD_MOV, CMD_BIC, CMD_MVN});
  endfunction

endpackage

// File: rtl/arm_dp_controller_if.sv
// Instruction handshake and datapath control bundle of the data-processing
// controller; the controller uses the slave view, the source/datapath the master.
interface arm_dp_controller_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [31:0] IR;
  logic        IRWrite;
  logic        ALUSrcB;
  logic [3:0]  ALUControl;
  logic        RegWrite;
  logic [3:0]  Flags;
  logic        busy;
  logic        illegal;

  modport slave (
    input  instr_valid, Instr, ALUFlags,
    output instr_ready, IR, IRWrite, ALUSrcB, ALUControl, RegWrite, Flags, busy, illegal
  );

  modport master (
    output instr_valid, Instr, ALUFlags,
    input  instr_ready, IR, IRWrite, ALUSrcB, ALUControl, RegWrite, Flags, busy, illegal
  );
endinterface

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV value; kept as
// its own block so branch logic can reuse it.
module arm_cond_check
  import arm_dp_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_pass
);

  assign cond_pass = cond_holds(cond, nzcv);

endmodule

// File: rtl/arm_dp_controller.sv
// Multi-cycle control FSM for ARM data-processing instructions: latches the
// instruction, checks its condition, sequences ALU control and write-back, owns NZCV.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FETCH   | idle, instr_ready high, accept on instr_valid
// ST_DECODE  | classify IR: illegal, condition failed, or execute
// ST_EXECUTE | drive ALU source select and command
// ST_ALUWB   | hold ALU controls, write Rd and/or update flags
// ST_ILLEGAL | one-cycle illegal pulse, no writes
module arm_dp_controller
  import arm_dp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  arm_dp_controller_if.slave    bus
);

  state_t    state_q, state_d;
  dp_instr_t ir_q;
  logic [3:0] flags_q, flags_d;
  logic       flag_we;
  logic       cond_pass;
  logic       accept;

  logic       rdy, irw, srcb, rw, bsy, ill;
  logic [3:0] ctl;

  arm_cond_check u_cond_check (
    .cond      (ir_q.cond),
    .nzcv      (flags_q),
    .cond_pass (cond_pass)
  );

  assign accept = (state_q == ST_FETCH) && bus.instr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ir_q <= bus.Instr;
      if (flag_we) flags_q <= flags_d;
    end
  end

  // N,Z always follow the ALU on a flag update; C,V only for adder commands.
  always_comb begin
    flag_we = (state_q == ST_ALUWB) && (ir_q.s || is_compare(ir_q.cmd));
    flags_d = {bus.ALUFlags[3:2], is_arith(ir_q.cmd) ? bus.ALUFlags[1:0] : flags_q[1:0]};
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    irw     = 1'b0;
    srcb    = 1'b0;
    ctl     = 4'b0000;
    rw      = 1'b0;
    ill     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        rdy = 1'b1;
        irw = bus.instr_valid;
        if (bus.instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (ir_q.op != 2'b00 || ir_q.cond == COND_NV) state_d = ST_ILLEGAL;
        else if (!cond_pass)                         state_d = ST_FETCH;
        else                                         state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        srcb    = ir_q.imm;
        ctl     = ir_q.cmd;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        srcb    = ir_q.imm;
        ctl     = ir_q.cmd;
        rw      = !is_compare(ir_q.cmd);
        state_d = ST_FETCH;
      end
      ST_ILLEGAL: begin
        ill     = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign bsy = (state_q != ST_FETCH);

  assign bus.instr_ready = rdy;
  assign bus.IRWrite     = irw;
  assign bus.ALUSrcB     = srcb;
  assign bus.ALUControl  = ctl;
  assign bus.RegWrite    = rw;
  assign bus.busy        = bsy;
  assign bus.illegal     = ill;
  assign bus.IR          = ir_q;
  assign bus.Flags       = flags_q;

endmodule

// File: tb/tb_arm_dp_controller.sv
// Bench for arm_dp_controller: directed vector table, hand-written reset and
// back-pressure sequences, and random instructions against a behavioural model.
module tb_arm_dp_controller;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  string tag = "init";
  logic [3:0] mflags;

  arm_dp_controller_if bus ();

  arm_dp_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  af;
    int          kind;   // 0 executed, 1 condition failed, 2 illegal
    logic        rw;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ARM condition rule: base test on cond[3:1], inverted by cond[0].
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return r ^ c[0];
  endfunction

  task automatic ref_model(input logic [31:0] ins, input logic [3:0] f, input logic [3:0] af,
                           output int kind, output logic rw, output logic [3:0] nf);
    logic [3:0] cmd;
    logic       cmp;
    cmd  = ins[24:21];
    nf   = f;
    rw   = 1'b0;
    kind = 0;
    if (ins[27:26] != 2'b00 || ins[31:28] == 4'hF) kind = 2;
    else if (!ref_cond(ins[31:28], f)) kind = 1;
    else begin
      cmp = (cmd >= 4'd8 && cmd <= 4'd11);
      rw  = !cmp;
      if (ins[20] || cmp) begin
        nf[3:2] = af[3:2];
        if ((cmd >= 4'd2 && cmd <= 4'd7) || cmd == 4'd10 || cmd == 4'd11) nf[1:0] = af[1:0];
      end
    end
  endtask

  // Issues one instruction from an idle FETCH and checks it cycle by cycle.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                           input int kind, input logic rw, input logic [3:0] eflags);
    chk("pre.instr_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.Instr       = ins;
    bus.ALUFlags    = af;
    #1;
    chk("c0.IRWrite", 32'(bus.IRWrite), 32'd1);
    step();
    bus.instr_valid = 1'b0;
    bus.Instr       = 32'hDEAD_BEEF;
    #1;
    chk("c1.IR", bus.IR, ins);
    chk("c1.busy", 32'(bus.busy), 32'd1);
    chk("c1.RegWrite", 32'(bus.RegWrite), 32'd0);
    if (kind == 2) begin
      step();
      chk("c2.illegal", 32'(bus.illegal), 32'd1);
      chk("c2.RegWrite", 32'(bus.RegWrite), 32'd0);
      step();
      chk("c3.illegal", 32'(bus.illegal), 32'd0);
      chk("c3.instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("c3.Flags", 32'(bus.Flags), 32'(eflags));
    end else if (kind == 1) begin
      step();
      chk("c2.instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("c2.RegWrite", 32'(bus.RegWrite), 32'd0);
      chk("c2.Flags", 32'(bus.Flags), 32'(eflags));
    end else begin
      step();
      chk("c2.ALUSrcB", 32'(bus.ALUSrcB), 32'(ins[25]));
      chk("c2.ALUControl", 32'(bus.ALUControl), 32'(ins[24:21]));
      chk("c2.RegWrite", 32'(bus.RegWrite), 32'd0);
      step();
      chk("c3.ALUSrcB", 32'(bus.ALUSrcB), 32'(ins[25]));
      chk("c3.ALUControl", 32'(bus.ALUControl), 32'(ins[24:21]));
      chk("c3.RegWrite", 32'(bus.RegWrite), 32'(rw));
      chk("c3.illegal", 32'(bus.illegal), 32'd0);
      step();
      chk("c4.instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("c4.RegWrite", 32'(bus.RegWrite), 32'd0);
      chk("c4.ALUControl", 32'(bus.ALUControl), 32'd0);
      chk("c4.Flags", 32'(bus.Flags), 32'(eflags));
    end
  endtask

  initial begin
    int         kind;
    logic       rw;
    logic [3:0] nf;
    logic [31:0] ins;
    int         seen_rw;
    bit         done;

    tbl[0]  = '{32'hE0921003, 4'b0000, 0, 1'b1, 4'b0000};  // ADDS
    tbl[1]  = '{32'hE1510002, 4'b0110, 0, 1'b0, 4'b0110};  // CMP
    tbl[2]  = '{32'h03A00005, 4'b1111, 0, 1'b1, 4'b0110};  // MOVEQ taken
    tbl[3]  = '{32'hE1510002, 4'b0000, 0, 1'b0, 4'b0000};  // CMP clears Z
    tbl[4]  = '{32'h03A00005, 4'b1111, 1, 1'b0, 4'b0000};  // MOVEQ skipped
    tbl[5]  = '{32'hE5912000, 4'b1111, 2, 1'b0, 4'b0000};  // LDR
    tbl[6]  = '{32'hF0000000, 4'b1111, 2, 1'b0, 4'b0000};  // cond NV
    tbl[7]  = '{32'hE1510002, 4'b0011, 0, 1'b0, 4'b0011};  // CMP sets C,V
    tbl[8]  = '{32'hE0121003, 4'b1000, 0, 1'b1, 4'b1011};  // ANDS keeps C,V
    tbl[9]  = '{32'hE0821003, 4'b1111, 0, 1'b1, 4'b1011};  // ADD, no S
    tbl[10] = '{32'hE1300000, 4'b0100, 0, 1'b0, 4'b0111};  // TEQ
    tbl[11] = '{32'hE0921003, 4'b0101, 0, 1'b1, 4'b0101};  // ADDS
    tbl[12] = '{32'hC0921003, 4'b1111, 1, 1'b0, 4'b0101};  // GT fails on Z
    tbl[13] = '{32'hD0921003, 4'b1010, 0, 1'b1, 4'b1010};  // LE passes on Z

    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.Instr       = 32'h0;
    bus.ALUFlags    = 4'h0;
    step();
    step();
    reset = 1'b0;
    step();

    tag = "reset";
    chk("instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("busy", 32'(bus.busy), 32'd0);
    chk("IRWrite", 32'(bus.IRWrite), 32'd0);
    chk("RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("illegal", 32'(bus.illegal), 32'd0);
    chk("ALUSrcB", 32'(bus.ALUSrcB), 32'd0);
    chk("ALUControl", 32'(bus.ALUControl), 32'd0);
    chk("Flags", 32'(bus.Flags), 32'd0);
    chk("IR", bus.IR, 32'd0);

    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("vec%0d", i);
      run_instr(tbl[i].ins, tbl[i].af, tbl[i].kind, tbl[i].rw, tbl[i].flags);
    end
    mflags = tbl[13].flags;

    // Reset asserted while in EXECUTE aborts the instruction.
    tag = "rst_mid";
    bus.instr_valid = 1'b1;
    bus.Instr       = 32'hE0921003;
    bus.ALUFlags    = 4'b0101;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("exec.ALUControl", 32'(bus.ALUControl), 32'h4);
    reset = 1'b1;
    #1;
    chk("instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("busy", 32'(bus.busy), 32'd0);
    chk("RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("ALUControl", 32'(bus.ALUControl), 32'd0);
    chk("Flags", 32'(bus.Flags), 32'd0);
    chk("IR", bus.IR, 32'd0);
    step();
    chk("held.RegWrite", 32'(bus.RegWrite), 32'd0);
    reset = 1'b0;
    step();
    chk("after.RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("after.Flags", 32'(bus.Flags), 32'd0);
    chk("after.instr_ready", 32'(bus.instr_ready), 32'd1);
    mflags = 4'b0000;

    // instr_valid held through a busy instruction must not re-sample Instr.
    tag = "backpressure";
    bus.instr_valid = 1'b1;
    bus.Instr       = 32'hE3A00001;
    bus.ALUFlags    = 4'b0100;
    #1;
    chk("c0.IRWrite", 32'(bus.IRWrite), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      bus.Instr = 32'hE3B00000;
      #1;
      chk("busy.IRWrite", 32'(bus.IRWrite), 32'd0);
      chk("busy.IR", bus.IR, 32'hE3A00001);
      chk("busy.instr_ready", 32'(bus.instr_ready), 32'd0);
    end
    step();
    chk("c4.instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("c4.IRWrite", 32'(bus.IRWrite), 32'd1);
    step();
    bus.instr_valid = 1'b0;
    #1;
    chk("c5.IR", bus.IR, 32'hE3B00000);
    seen_rw = 0;
    done    = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      if (bus.RegWrite) seen_rw++;
      if (bus.instr_ready) done = 1'b1;
      else step();
    end
    chk("drain.done", 32'(done), 32'd1);
    chk("drain.RegWrite_pulses", 32'(seen_rw), 32'd1);
    chk("drain.Flags", 32'(bus.Flags), 32'b0100);
    mflags = 4'b0100;

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  c;
      logic [1:0]  op;
      logic [3:0]  af;
      tag = $sformatf("rand%0d", i);
      c  = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      op = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ins = {c, op, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 20'($urandom())};
      af = 4'($urandom_range(0, 15));
      ref_model(ins, mflags, af, kind, rw, nf);
      run_instr(ins, af, kind, rw, nf);
      mflags = nf;
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("idle.instr_ready", 32'(bus.instr_ready), 32'd1);
        chk("idle.IRWrite", 32'(bus.IRWrite), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
